// File: rtl/datacheck_run_sequencer_if.sv
// Snapshot readout stream of the datacheck run sequencer: one counter word
// per valid/ready transfer, tagged with its index.
interface datacheck_run_sequencer_if #(
  parameter int NCNT  = 8,
  parameter int CNT_W = 20
);
  localparam int IDX_W = (NCNT > 1) ? $clog2(NCNT) : 1;

  logic [CNT_W-1:0] rdData;
  logic [IDX_W-1:0] rdIdx;
  logic             rdValid;
  logic             rdReady;

  modport master (output rdData, output rdIdx, output rdValid, input rdReady);
  modport slave  (input rdData, input rdIdx, input rdValid, output rdReady);
endinterface

// File: rtl/datacheck_run_sequencer.sv
// Sequences one pixel-data-check run: clear the checker, enable it for a
// programmed number of events, drain, snapshot the checker counters, then
// stream the snapshot out. Owns the checker's reset and enable.
// The interface on rd must be instantiated with the same NCNT/CNT_W.
module datacheck_run_sequencer #(
  parameter int NCNT      = 8,
  parameter int CNT_W     = 20,
  parameter int CLR_CYC   = 2,
  parameter int DRAIN_CYC = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      runLength,
  input  logic                  eventStart,
  input  logic [NCNT*CNT_W-1:0] cntIn,
  output logic                  chkReset,
  output logic                  chkEnable,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      eventsSeen,
  datacheck_run_sequencer_if.master rd
);
  localparam int IDX_W   = (NCNT > 1) ? $clog2(NCNT) : 1;
  localparam int CYC_MAX = (CLR_CYC > DRAIN_CYC) ? CLR_CYC : DRAIN_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCNT - 1);
  localparam logic [CYC_W-1:0] CLR_LAST   = CYC_W'(CLR_CYC - 1);
  localparam logic [CYC_W-1:0] DRAIN_LAST = CYC_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, SNAP, READ} state_t;

  state_t           state_reg;
  logic [CYC_W-1:0] cyc_reg;
  logic [CNT_W-1:0] run_len_reg;
  logic [CNT_W-1:0] snap_reg [NCNT];
  logic [CNT_W-1:0] cnt_word [NCNT];
  logic [CNT_W-1:0] events_next;
  logic             run_hit;
  logic [IDX_W-1:0] idx_next;

  // Unpack the flat counter bus into words.
  generate
    for (genvar gi = 0; gi < NCNT; gi++) begin : g_unpack
      assign cnt_word[gi] = cntIn[gi*CNT_W +: CNT_W];
    end
  endgenerate

  assign idx_next = rd.rdIdx + 1'b1;

  // Saturating event count and run-length match; a zero run length never matches.
  always_comb begin
    events_next = eventsSeen;
    if (eventStart && (eventsSeen != '1)) begin
      events_next = eventsSeen + 1'b1;
    end
    run_hit = (run_len_reg != '0) && (events_next == run_len_reg);
  end

  // Run sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cyc_reg     <= '0;
      run_len_reg <= '0;
      chkReset    <= 1'b1;
      chkEnable   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      eventsSeen  <= '0;
      rd.rdValid  <= 1'b0;
      rd.rdIdx    <= '0;
      rd.rdData   <= '0;
      for (int k = 0; k < NCNT; k++) snap_reg[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= CLEAR;
            cyc_reg     <= '0;
            run_len_reg <= runLength;
            eventsSeen  <= '0;
            chkReset    <= 1'b0;
            busy        <= 1'b1;
          end
        end
        CLEAR: begin
          if (cyc_reg == CLR_LAST) begin
            state_reg <= RUN;
            chkReset  <= 1'b1;
            chkEnable <= 1'b1;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        RUN: begin
          // The final event is counted even when abort arrives with it.
          eventsSeen <= events_next;
          if (run_hit || abort) begin
            state_reg <= DRAIN;
            chkEnable <= 1'b0;
            cyc_reg   <= '0;
          end
        end
        DRAIN: begin
          if (cyc_reg == DRAIN_LAST) begin
            state_reg <= SNAP;
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        SNAP: begin
          for (int k = 0; k < NCNT; k++) snap_reg[k] <= cnt_word[k];
          state_reg  <= READ;
          rd.rdValid <= 1'b1;
          rd.rdIdx   <= '0;
          rd.rdData  <= cnt_word[0];
        end
        READ: begin
          if (abort) begin
            state_reg  <= IDLE;
            rd.rdValid <= 1'b0;
            rd.rdIdx   <= '0;
            busy       <= 1'b0;
          end else if (rd.rdReady) begin
            if (rd.rdIdx == LAST_IDX) begin
              state_reg  <= IDLE;
              rd.rdValid <= 1'b0;
              rd.rdIdx   <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              rd.rdIdx  <= idx_next;
              rd.rdData <= snap_reg[idx_next];
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datacheck_run_sequencer.sv
// Directed bench for datacheck_run_sequencer: inputs change and outputs are
// observed on the falling edge; the DUT samples on the rising edge.
`timescale 1ns/1ps
module tb_datacheck_run_sequencer;
  localparam int NCNT      = 8;
  localparam int CNT_W     = 20;
  localparam int CLR_CYC   = 2;
  localparam int DRAIN_CYC = 4;
  localparam int IDX_W     = $clog2(NCNT);

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic                  abort;
  logic [CNT_W-1:0]      runLength;
  logic                  eventStart;
  logic [NCNT*CNT_W-1:0] cntIn;
  logic                  chkReset;
  logic                  chkEnable;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      eventsSeen;

  int check_cnt    = 0;
  int pass_cnt     = 0;
  int conflict_cnt = 0;

  logic [CNT_W-1:0] exp_word [NCNT];
  logic [CNT_W-1:0] got_word [NCNT+4];
  int               got_idx  [NCNT+4];
  int               got_n, ndone, stall_err, early_done;

  datacheck_run_sequencer_if #(.NCNT(NCNT), .CNT_W(CNT_W)) rd_bus ();

  datacheck_run_sequencer #(
    .NCNT(NCNT), .CNT_W(CNT_W), .CLR_CYC(CLR_CYC), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .runLength(runLength), .eventStart(eventStart), .cntIn(cntIn),
    .chkReset(chkReset), .chkEnable(chkEnable), .busy(busy), .done(done),
    .eventsSeen(eventsSeen), .rd(rd_bus)
  );

  always #5 clk = ~clk;

  // Track any cycle where the checker is both held in reset and enabled.
  always @(negedge clk) begin
    if (reset === 1'b1 && chkReset === 1'b0 && chkEnable === 1'b1) conflict_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_cnt(input int base);
    for (int k = 0; k < NCNT; k++) begin
      exp_word[k] = CNT_W'(base + k * 4099 + 1);
      cntIn[k*CNT_W +: CNT_W] = exp_word[k];
    end
  endtask

  task automatic launch(input logic [CNT_W-1:0] len);
    runLength = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_run(output int low);
    low = 0;
    while (chkReset === 1'b0 && low < 20) begin
      low++;
      step();
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (rd_bus.rdValid !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    if (rd_bus.rdValid !== 1'b1) cyc = -1;
  endtask

  task automatic collect(input bit toggle);
    int               ph = 0;
    int               idle_after = 0;
    bit               have_prev = 1'b0;
    logic [CNT_W-1:0] prev_data = '0;
    logic [IDX_W-1:0] prev_idx = '0;
    got_n = 0; ndone = 0; stall_err = 0; early_done = 0;
    for (int c = 0; c < 300 && idle_after < 3; c++) begin
      if (have_prev && rd_bus.rdValid === 1'b1 &&
          (rd_bus.rdIdx !== prev_idx || rd_bus.rdData !== prev_data)) stall_err++;
      rd_bus.rdReady = toggle ? (ph % 3 == 0) : 1'b1;
      if (rd_bus.rdValid === 1'b1 && rd_bus.rdReady) begin
        $display("read idx=%0d data=%h", rd_bus.rdIdx, rd_bus.rdData);
        if (got_n < NCNT + 4) begin
          got_word[got_n] = rd_bus.rdData;
          got_idx[got_n]  = int'(rd_bus.rdIdx);
        end
        got_n++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (got_n == 0 || got_n > NCNT + 4) early_done++;
        else if (got_idx[got_n-1] != NCNT - 1) early_done++;
      end
      have_prev = (rd_bus.rdValid === 1'b1) && !rd_bus.rdReady;
      prev_idx  = rd_bus.rdIdx;
      prev_data = rd_bus.rdData;
      if (busy === 1'b0) idle_after++;
      ph++;
      step();
    end
    rd_bus.rdReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    check_cnt++; if (chkReset !== 1'b1) $display("FAIL reset_chkReset: got %b want 1", chkReset); else pass_cnt++;
    check_cnt++; if (chkEnable !== 1'b0) $display("FAIL reset_chkEnable: got %b want 0", chkEnable); else pass_cnt++;
    check_cnt++; if (rd_bus.rdValid !== 1'b0) $display("FAIL reset_rdValid: got %b want 0", rd_bus.rdValid); else pass_cnt++;
    check_cnt++; if (rd_bus.rdIdx !== '0 || rd_bus.rdData !== '0) $display("FAIL reset_rd: got idx=%0d data=%h want 0/0", rd_bus.rdIdx, rd_bus.rdData); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy, done); else pass_cnt++;
    check_cnt++; if (eventsSeen !== '0) $display("FAIL reset_eventsSeen: got %0d want 0", eventsSeen); else pass_cnt++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int low, lat;
    launch(CNT_W'(5));
    check_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else pass_cnt++;
    wait_run(low);
    check_cnt++; if (low != CLR_CYC) $display("FAIL basic_clr_len: got %0d want %0d", low, CLR_CYC); else pass_cnt++;
    check_cnt++; if (chkEnable !== 1'b1) $display("FAIL basic_enable_on: got %b want 1", chkEnable); else pass_cnt++;
    eventStart = 1'b1;
    repeat (4) step();
    check_cnt++; if (eventsSeen !== 20'd4 || chkEnable !== 1'b1) $display("FAIL basic_ev4: got ev=%0d en=%b want 4/1", eventsSeen, chkEnable); else pass_cnt++;
    step();
    eventStart = 1'b0;
    check_cnt++; if (eventsSeen !== 20'd5 || chkEnable !== 1'b0) $display("FAIL basic_ev5: got ev=%0d en=%b want 5/0", eventsSeen, chkEnable); else pass_cnt++;
    set_cnt(100);
    wait_valid(lat);
    check_cnt++; if (lat != DRAIN_CYC + 1) $display("FAIL basic_drain_lat: got %0d want %0d", lat, DRAIN_CYC + 1); else pass_cnt++;
    cntIn = ~cntIn;
    collect(1'b0);
    check_cnt++; if (got_n != NCNT) $display("FAIL basic_nwords: got %0d want %0d", got_n, NCNT); else pass_cnt++;
    for (int k = 0; k < NCNT && k < got_n; k++) begin
      check_cnt++;
      if (got_word[k] !== exp_word[k] || got_idx[k] != k)
        $display("FAIL basic_word%0d: got idx=%0d data=%h want idx=%0d data=%h", k, got_idx[k], got_word[k], k, exp_word[k]);
      else pass_cnt++;
    end
    check_cnt++; if (ndone != 1 || early_done != 0) $display("FAIL basic_done: got pulses=%0d early=%0d want 1/0", ndone, early_done); else pass_cnt++;
    check_cnt++; if (eventsSeen !== 20'd5) $display("FAIL basic_ev_hold: got %0d want 5", eventsSeen); else pass_cnt++;
  endtask

  task automatic test_run_until_abort();
    int low, lat;
    launch('0);
    wait_run(low);
    for (int i = 0; i < 100; i++) begin
      eventStart = 1'b1; step();
      eventStart = 1'b0; step();
    end
    check_cnt++; if (eventsSeen !== 20'd100 || chkEnable !== 1'b1) $display("FAIL len0_hold: got ev=%0d en=%b want 100/1", eventsSeen, chkEnable); else pass_cnt++;
    abort = 1'b1; step(); abort = 1'b0;
    check_cnt++; if (eventsSeen !== 20'd100 || chkEnable !== 1'b0) $display("FAIL len0_abort: got ev=%0d en=%b want 100/0", eventsSeen, chkEnable); else pass_cnt++;
    set_cnt(7);
    wait_valid(lat);
    collect(1'b0);
    check_cnt++; if (got_n != NCNT || ndone != 1) $display("FAIL len0_read: got words=%0d done=%0d want %0d/1", got_n, ndone, NCNT); else pass_cnt++;
    check_cnt++; if (got_word[NCNT-1] !== exp_word[NCNT-1]) $display("FAIL len0_last: got %h want %h", got_word[NCNT-1], exp_word[NCNT-1]); else pass_cnt++;
  endtask

  task automatic test_stall();
    int low, lat;
    launch(CNT_W'(2));
    wait_run(low);
    eventStart = 1'b1; step(); step(); eventStart = 1'b0;
    set_cnt(2000);
    wait_valid(lat);
    collect(1'b1);
    check_cnt++; if (stall_err != 0) $display("FAIL stall_stable: got %0d changes want 0", stall_err); else pass_cnt++;
    check_cnt++; if (got_n != NCNT) $display("FAIL stall_nwords: got %0d want %0d", got_n, NCNT); else pass_cnt++;
    for (int k = 0; k < NCNT && k < got_n; k++) begin
      check_cnt++;
      if (got_word[k] !== exp_word[k] || got_idx[k] != k)
        $display("FAIL stall_word%0d: got idx=%0d data=%h want idx=%0d data=%h", k, got_idx[k], got_word[k], k, exp_word[k]);
      else pass_cnt++;
    end
    check_cnt++; if (ndone != 1 || early_done != 0) $display("FAIL stall_done: got pulses=%0d early=%0d want 1/0", ndone, early_done); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int low, lat;
    launch(CNT_W'(3));
    wait_run(low);
    eventStart = 1'b1; step(); eventStart = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check_cnt++; if (chkReset !== 1'b1 || chkEnable !== 1'b1 || eventsSeen !== 20'd1) $display("FAIL start_in_run: got rst=%b en=%b ev=%0d want 1/1/1", chkReset, chkEnable, eventsSeen); else pass_cnt++;
    eventStart = 1'b1; step(); step(); eventStart = 1'b0;
    set_cnt(300);
    wait_valid(lat);
    rd_bus.rdReady = 1'b1; step(); step(); rd_bus.rdReady = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check_cnt++; if (rd_bus.rdIdx !== 3'd2 || rd_bus.rdValid !== 1'b1 || busy !== 1'b1) $display("FAIL start_in_read: got idx=%0d v=%b busy=%b want 2/1/1", rd_bus.rdIdx, rd_bus.rdValid, busy); else pass_cnt++;
    check_cnt++; if (rd_bus.rdData !== exp_word[2]) $display("FAIL start_in_read_data: got %h want %h", rd_bus.rdData, exp_word[2]); else pass_cnt++;
    collect(1'b0);
    check_cnt++; if (got_n != NCNT - 2 || got_idx[0] != 2) $display("FAIL start_rest: got words=%0d first=%0d want %0d/2", got_n, got_idx[0], NCNT - 2); else pass_cnt++;
    check_cnt++; if (got_word[NCNT-3] !== exp_word[NCNT-1] || ndone != 1) $display("FAIL start_last: got %h done=%0d want %h/1", got_word[NCNT-3], ndone, exp_word[NCNT-1]); else pass_cnt++;
    check_cnt++; if (eventsSeen !== 20'd3) $display("FAIL start_ev: got %0d want 3", eventsSeen); else pass_cnt++;
  endtask

  task automatic test_abort_last_event();
    int low, lat;
    set_cnt(4242);
    launch(CNT_W'(3));
    wait_run(low);
    eventStart = 1'b1; step(); step();
    abort = 1'b1; step();
    eventStart = 1'b0; abort = 1'b0;
    check_cnt++; if (eventsSeen !== 20'd3 || chkEnable !== 1'b0) $display("FAIL abort_last: got ev=%0d en=%b want 3/0", eventsSeen, chkEnable); else pass_cnt++;
    eventStart = 1'b1; step(); eventStart = 1'b0;
    check_cnt++; if (eventsSeen !== 20'd3) $display("FAIL drain_no_count: got %0d want 3", eventsSeen); else pass_cnt++;
    wait_valid(lat);
    check_cnt++; if (lat != DRAIN_CYC) $display("FAIL abort_drain_lat: got %0d want %0d", lat, DRAIN_CYC); else pass_cnt++;
    collect(1'b0);
    check_cnt++; if (got_n != NCNT || ndone != 1) $display("FAIL abort_read: got words=%0d done=%0d want %0d/1", got_n, ndone, NCNT); else pass_cnt++;
  endtask

  task automatic test_read_abort();
    int low, lat;
    launch(CNT_W'(1));
    wait_run(low);
    eventStart = 1'b1; step(); eventStart = 1'b0;
    set_cnt(9);
    wait_valid(lat);
    rd_bus.rdReady = 1'b1; step(); rd_bus.rdReady = 1'b0;
    check_cnt++; if (rd_bus.rdIdx !== 3'd1 || rd_bus.rdData !== exp_word[1]) $display("FAIL rabort_idx1: got idx=%0d data=%h want 1/%h", rd_bus.rdIdx, rd_bus.rdData, exp_word[1]); else pass_cnt++;
    abort = 1'b1; step(); abort = 1'b0;
    check_cnt++; if (rd_bus.rdValid !== 1'b0 || rd_bus.rdIdx !== '0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL rabort_state: got v=%b idx=%0d busy=%b done=%b want 0/0/0/0", rd_bus.rdValid, rd_bus.rdIdx, busy, done); else pass_cnt++;
    step();
    check_cnt++; if (done !== 1'b0) $display("FAIL rabort_no_done: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_reset_in_read();
    int low, lat;
    launch(CNT_W'(2));
    wait_run(low);
    eventStart = 1'b1; step(); step(); eventStart = 1'b0;
    set_cnt(77);
    wait_valid(lat);
    rd_bus.rdReady = 1'b1; repeat (4) step(); rd_bus.rdReady = 1'b0;
    check_cnt++; if (rd_bus.rdIdx !== 3'd4) $display("FAIL rst_read_idx: got %0d want 4", rd_bus.rdIdx); else pass_cnt++;
    reset = 1'b0; step();
    check_cnt++; if (chkReset !== 1'b1 || chkEnable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_read_ctrl: got rst=%b en=%b busy=%b done=%b want 1/0/0/0", chkReset, chkEnable, busy, done); else pass_cnt++;
    check_cnt++; if (rd_bus.rdValid !== 1'b0 || rd_bus.rdIdx !== '0 || rd_bus.rdData !== '0 || eventsSeen !== '0) $display("FAIL rst_read_out: got v=%b idx=%0d data=%h ev=%0d want 0/0/0/0", rd_bus.rdValid, rd_bus.rdIdx, rd_bus.rdData, eventsSeen); else pass_cnt++;
    reset = 1'b1; step();
    check_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rst_read_idle: got done=%b busy=%b want 0/0", done, busy); else pass_cnt++;
    launch(CNT_W'(1));
    wait_run(low);
    eventStart = 1'b1; step(); eventStart = 1'b0;
    set_cnt(55);
    wait_valid(lat);
    collect(1'b0);
    check_cnt++; if (got_n != NCNT || ndone != 1) $display("FAIL rst_fresh_run: got words=%0d done=%0d want %0d/1", got_n, ndone, NCNT); else pass_cnt++;
    check_cnt++; if (got_word[0] !== exp_word[0] || eventsSeen !== 20'd1) $display("FAIL rst_fresh_data: got %h ev=%0d want %h/1", got_word[0], eventsSeen, exp_word[0]); else pass_cnt++;
  endtask

  task automatic test_exclusive();
    check_cnt++; if (conflict_cnt != 0) $display("FAIL rst_en_overlap: got %0d cycles want 0", conflict_cnt); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; eventStart = 1'b0;
    runLength = '0; cntIn = '0; rd_bus.rdReady = 1'b0;
    test_reset();
    test_basic();
    test_run_until_abort();
    test_stall();
    test_start_ignored();
    test_abort_last_event();
    test_read_abort();
    test_reset_in_read();
    test_exclusive();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
